// File: rtl/poly_osc_bank_if.sv
// Note/tick control inputs and mixed-audio outputs of the oscillator bank.
interface poly_osc_bank_if #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int DAC_WIDTH  = 12
) ();
    logic                  i_Note_Valid;
    logic                  i_Note_On;
    logic [6:0]            i_Note_Num;
    logic [ACC_WIDTH-1:0]  i_Phase_Inc;
    logic [1:0]            i_Waveform_Sel;
    logic                  i_Sample_Tick;
    logic [DAC_WIDTH-1:0]  o_Audio;
    logic                  o_Audio_Valid;
    logic [NUM_VOICES-1:0] o_Voices_Active;
    logic                  o_Voice_Steal;
    logic                  o_Tick_Overrun;

    modport master (
        output i_Note_Valid, i_Note_On, i_Note_Num, i_Phase_Inc, i_Waveform_Sel, i_Sample_Tick,
        input  o_Audio, o_Audio_Valid, o_Voices_Active, o_Voice_Steal, o_Tick_Overrun
    );

    modport slave (
        input  i_Note_Valid, i_Note_On, i_Note_Num, i_Phase_Inc, i_Waveform_Sel, i_Sample_Tick,
        output o_Audio, o_Audio_Valid, o_Voices_Active, o_Voice_Steal, o_Tick_Overrun
    );
endinterface

// File: rtl/poly_osc_bank.sv
// Polyphonic oscillator bank: per-voice phase accumulators, note allocation
// with retrigger/steal, and a serial mixer that scans one voice per cycle.
//
// state | meaning
// IDLE  | waiting for a sample tick; ticks are only accepted here
// SCAN  | summing voice scan_idx into the accumulator, one voice per cycle
// OUT   | publishing the averaged mix on o_Audio with a valid pulse
module poly_osc_bank #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int DAC_WIDTH  = 12
) (
    input  logic           i_Clk,
    input  logic           reset,
    poly_osc_bank_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int SUM_W = DAC_WIDTH + IDX_W;

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       scan_idx;
    logic [SUM_W-1:0]       acc;
    logic [DAC_WIDTH-1:0]   audio;
    logic                   audio_valid;
    logic                   voice_steal;
    logic                   tick_overrun;
    logic [15:0]            lfsr;
    logic [IDX_W-1:0]       steal_ptr;

    logic [NUM_VOICES-1:0]  active;
    logic [6:0]             note  [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   inc   [NUM_VOICES];
    logic [1:0]             wave  [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   phase [NUM_VOICES];

    logic                   tick_acc;
    logic                   tick_drop;
    logic                   match_hit, free_hit;
    logic [IDX_W-1:0]       match_idx, free_idx;
    logic                   load_en, off_en, steal_en;
    logic [IDX_W-1:0]       sel_idx;

    logic [ACC_WIDTH-1:0]   cur_phase;
    logic [DAC_WIDTH-1:0]   saw, tri_raw, noise, sample;

    assign tick_acc  = bus.i_Sample_Tick && (state == IDLE);
    assign tick_drop = bus.i_Sample_Tick && (state != IDLE);

    // Lowest-index active voice holding the note, and lowest-index free voice.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (active[v] && (note[v] == bus.i_Note_Num)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(v);
            end
            if (!active[v]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(v);
            end
        end
    end

    // Decide which voice a note event touches: retrigger, free slot, or steal.
    always_comb begin
        load_en  = 1'b0;
        off_en   = 1'b0;
        steal_en = 1'b0;
        sel_idx  = '0;
        if (bus.i_Note_Valid) begin
            if (bus.i_Note_On) begin
                load_en = 1'b1;
                if (match_hit) begin
                    sel_idx = match_idx;
                end else if (free_hit) begin
                    sel_idx = free_idx;
                end else begin
                    sel_idx  = steal_ptr;
                    steal_en = 1'b1;
                end
            end else if (match_hit) begin
                off_en  = 1'b1;
                sel_idx = match_idx;
            end
        end
    end

    // Voice state; a note load or release on the same edge as a tick wins over the advance.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            active    <= '0;
            steal_ptr <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note[v]  <= '0;
                inc[v]   <= '0;
                wave[v]  <= '0;
                phase[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (load_en && (sel_idx == IDX_W'(v))) begin
                    active[v] <= 1'b1;
                    note[v]   <= bus.i_Note_Num;
                    inc[v]    <= bus.i_Phase_Inc;
                    wave[v]   <= bus.i_Waveform_Sel;
                    phase[v]  <= '0;
                end else if (off_en && (sel_idx == IDX_W'(v))) begin
                    active[v] <= 1'b0;
                    phase[v]  <= '0;
                end else if (tick_acc && active[v]) begin
                    phase[v] <= phase[v] + inc[v];
                end
            end
            if (steal_en) begin
                steal_ptr <= steal_ptr + 1'b1;
            end
        end
    end

    // Shared noise source, taps 16,14,13,11, stepped once per accepted tick.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (tick_acc) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Waveform of the voice currently under the scan pointer.
    always_comb begin
        cur_phase = phase[scan_idx];
        saw       = DAC_WIDTH'(cur_phase >> (ACC_WIDTH - DAC_WIDTH));
        tri_raw   = DAC_WIDTH'(cur_phase >> (ACC_WIDTH - DAC_WIDTH - 1));
        noise     = DAC_WIDTH'(lfsr >> (16 - DAC_WIDTH));
        sample    = '0;
        if (active[scan_idx]) begin
            case (wave[scan_idx])
                2'b00:   sample = saw;
                2'b01:   sample = cur_phase[ACC_WIDTH-1] ? '0 : '1;
                2'b10:   sample = cur_phase[ACC_WIDTH-1] ? ~tri_raw : tri_raw;
                default: sample = noise;
            endcase
        end
    end

    // Mixer state register.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mixer next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick_acc) state_nxt = SCAN;
            SCAN:    if (scan_idx == IDX_W'(NUM_VOICES - 1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Mixer datapath and one-cycle status pulses.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            scan_idx     <= '0;
            acc          <= '0;
            audio        <= '0;
            audio_valid  <= 1'b0;
            voice_steal  <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            audio_valid  <= 1'b0;
            voice_steal  <= steal_en;
            tick_overrun <= tick_drop;
            case (state)
                IDLE: begin
                    if (tick_acc) begin
                        scan_idx <= '0;
                        acc      <= '0;
                    end
                end
                SCAN: begin
                    acc      <= acc + SUM_W'(sample);
                    scan_idx <= scan_idx + 1'b1;
                end
                OUT: begin
                    audio       <= DAC_WIDTH'(acc >> IDX_W);
                    audio_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_Audio         = audio;
    assign bus.o_Audio_Valid   = audio_valid;
    assign bus.o_Voices_Active = active;
    assign bus.o_Voice_Steal   = voice_steal;
    assign bus.o_Tick_Overrun  = tick_overrun;
endmodule

// File: tb/tb_poly_osc_bank.sv
// Scoreboard bench for poly_osc_bank: a voice-level reference model predicts
// each mixed sample when its tick is issued; a monitor pops on o_Audio_Valid.
module tb_poly_osc_bank;
    localparam int NV = 4;
    localparam int AW = 16;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_osc_bank_if #(.NUM_VOICES(NV), .ACC_WIDTH(AW), .DAC_WIDTH(DW)) bus ();

    poly_osc_bank #(.NUM_VOICES(NV), .ACC_WIDTH(AW), .DAC_WIDTH(DW)) dut (
        .i_Clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        longint at;
        int     val;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint edge_n = 0;
    exp_t   exp_q[$];

    bit          m_act   [NV];
    int          m_note  [NV];
    int unsigned m_inc   [NV];
    int          m_wave  [NV];
    int unsigned m_phase [NV];
    int          m_ptr;
    int unsigned m_lfsr;
    longint      busy_until;
    longint      last_tick_edge;
    int          exp_steal = 0, exp_over = 0;
    int          seen_steal = 0, seen_over = 0, seen_valid = 0;
    int          last_audio = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    function automatic int wave_of(int w, int unsigned p, int unsigned l);
        case (w)
            0:       return int'(p / 16);
            1:       return (p >= 32768) ? 0 : 4095;
            2:       return (p >= 32768) ? (4095 - int'((p / 8) % 4096)) : int'((p / 8) % 4096);
            default: return int'(l / 16);
        endcase
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_note[v] = 0; m_inc[v] = 0; m_wave[v] = 0; m_phase[v] = 0;
        end
        m_ptr          = 0;
        m_lfsr         = 16'hACE1;
        busy_until     = 0;
        last_tick_edge = -100;
        exp_q.delete();
    endfunction

    function automatic void model_note(bit on, int num, int unsigned inc, int w);
        int idx;
        idx = -1;
        for (int v = 0; v < NV; v++)
            if (idx < 0 && m_act[v] && m_note[v] == num) idx = v;
        if (!on) begin
            if (idx >= 0) begin
                m_act[idx] = 0;
                m_phase[idx] = 0;
            end
            return;
        end
        if (idx < 0)
            for (int v = 0; v < NV; v++)
                if (idx < 0 && !m_act[v]) idx = v;
        if (idx < 0) begin
            idx = m_ptr;
            m_ptr = (m_ptr + 1) % NV;
            exp_steal++;
        end
        m_act[idx] = 1; m_note[idx] = num; m_inc[idx] = inc; m_wave[idx] = w; m_phase[idx] = 0;
    endfunction

    function automatic void model_edge(bit nv, bit on, int num, int unsigned inc, int w, bit tick);
        bit accepted;
        int sum;
        int unsigned fb;
        if (rst) begin
            model_reset();
            return;
        end
        accepted = tick && (edge_n >= busy_until);
        if (accepted) begin
            for (int v = 0; v < NV; v++)
                if (m_act[v]) m_phase[v] = (m_phase[v] + m_inc[v]) % 65536;
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr * 2) + fb) % 65536;
        end else if (tick) begin
            exp_over++;
        end
        if (nv) model_note(on, num, inc, w);
        if (accepted) begin
            sum = 0;
            for (int v = 0; v < NV; v++)
                if (m_act[v]) sum += wave_of(m_wave[v], m_phase[v], m_lfsr);
            exp_q.push_back('{at: edge_n + NV + 1, val: sum / NV});
            busy_until     = edge_n + NV + 2;
            last_tick_edge = edge_n;
        end
    endfunction

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = m_act[v];
        return a;
    endfunction

    task automatic step(input bit nv, input bit on, input int num, input int unsigned inc,
                        input int w, input bit tick);
        bus.i_Note_Valid   = nv;
        bus.i_Note_On      = on;
        bus.i_Note_Num     = 7'(num);
        bus.i_Phase_Inc    = AW'(inc);
        bus.i_Waveform_Sel = 2'(w);
        bus.i_Sample_Tick  = tick;
        @(posedge clk);
        edge_n++;
        model_edge(nv, on, num, inc, w, tick);
        #1;
        bus.i_Note_Valid  = 1'b0;
        bus.i_Sample_Tick = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic note(input bit on, input int num, input int unsigned inc, input int w);
        step(1, on, num, inc, w, 0);
    endtask

    task automatic tick();
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int prev);
        int i;
        for (i = 0; i < 20; i++) begin
            if (seen_valid > prev) break;
            idle();
            settle();
        end
        if (seen_valid <= prev) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got no o_Audio_Valid expected one within 20 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    // Monitor: counts pulses and scores every presented sample against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_Voice_Steal === 1'b1) seen_steal++;
        if (bus.o_Tick_Overrun === 1'b1) seen_over++;
        if (bus.o_Audio_Valid === 1'b1) begin
            seen_valid++;
            last_audio = int'(bus.o_Audio);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got o_Audio=%0h expected no valid", bus.o_Audio);
            end else begin
                e = exp_q.pop_front();
                check("audio", 64'(bus.o_Audio), 64'(e.val));
                check("audio_latency_edge", 64'(edge_n), 64'(e.at));
            end
        end
    end

    initial begin
        int prev, prev2;
        bit allow;
        bus.i_Note_Valid = 0; bus.i_Note_On = 0; bus.i_Note_Num = 0;
        bus.i_Phase_Inc = 0; bus.i_Waveform_Sel = 0; bus.i_Sample_Tick = 0;
        model_reset();

        // reset state
        rst = 1'b1;
        idle();
        step(1, 1, 30, 16'h1234, 0, 1);
        settle();
        check("reset_audio", 64'(bus.o_Audio), 64'h0);
        check("reset_valid", 64'(bus.o_Audio_Valid), 64'h0);
        check("reset_active", 64'(bus.o_Voices_Active), 64'h0);
        check("reset_pulses", 64'({bus.o_Voice_Steal, bus.o_Tick_Overrun}), 64'h0);
        rst = 1'b0;

        // single saw voice
        idle();
        note(1, 60, 16'h1000, 0);
        prev = seen_valid;
        tick();
        wait_valid(prev);
        check("saw_mix", 64'(last_audio), 64'h040);

        // square at half-rate increment
        do_reset();
        note(1, 70, 16'h8000, 1);
        prev = seen_valid;
        tick();
        wait_valid(prev);
        check("square_tick1", 64'(last_audio), 64'h000);
        prev = seen_valid;
        tick();
        wait_valid(prev);
        check("square_tick2", 64'(last_audio), 64'h3FF);

        // allocation, steal, release
        do_reset();
        for (int n = 60; n < 64; n++) note(1, n, 16'h0100, 0);
        settle();
        check("active_full", 64'(bus.o_Voices_Active), 64'hF);
        prev = seen_steal;
        note(1, 64, 16'h0200, 2);
        settle();
        check("steal_pulse", 64'(seen_steal - prev), 64'd1);
        check("active_after_steal", 64'(bus.o_Voices_Active), 64'hF);
        note(0, 61, 0, 0);
        settle();
        check("off_61", 64'(bus.o_Voices_Active), 64'hD);
        note(0, 64, 0, 0);
        settle();
        check("off_64_voice0", 64'(bus.o_Voices_Active), 64'hC);
        note(0, 60, 0, 0);
        settle();
        check("off_stolen_60", 64'(bus.o_Voices_Active), 64'hC);
        note(1, 62, 16'h0300, 1);
        settle();
        check("retrigger_active", 64'(bus.o_Voices_Active), 64'hC);

        // tick overrun
        do_reset();
        note(1, 50, 16'h0400, 0);
        prev  = seen_valid;
        prev2 = seen_over;
        tick();
        idle();
        tick();
        wait_valid(prev);
        idle();
        settle();
        check("overrun_pulses", 64'(seen_over - prev2), 64'd1);
        check("overrun_single_advance", 64'(last_audio), 64'h010);

        // note-on and tick on the same edge
        do_reset();
        note(1, 10, 16'h1000, 0);
        prev = seen_valid;
        tick();
        wait_valid(prev);
        prev = seen_valid;
        step(1, 1, 20, 16'h2000, 0, 1);
        wait_valid(prev);
        check("same_edge_load", 64'(last_audio), 64'h080);

        // reset mid-scan
        note(1, 5, 16'h1111, 2);
        tick();
        idle();
        idle();
        prev = seen_valid;
        rst = 1'b1;
        idle();
        settle();
        check("midscan_audio", 64'(bus.o_Audio), 64'h0);
        check("midscan_active", 64'(bus.o_Voices_Active), 64'h0);
        rst = 1'b0;
        repeat (10) idle();
        settle();
        check("midscan_no_valid", 64'(seen_valid - prev), 64'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            allow = !((edge_n + 1 > last_tick_edge) && (edge_n + 1 < last_tick_edge + NV));
            step(allow && ($urandom_range(0, 2) == 0), $urandom_range(0, 2) != 0,
                 int'($urandom_range(60, 66)), $urandom_range(0, 16'hFFFF),
                 int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            if (i % 16 == 15) begin
                settle();
                check("rand_active", 64'(bus.o_Voices_Active), 64'(model_active()));
            end
        end
        repeat (12) idle();
        settle();
        check("pending_outputs", 64'(exp_q.size()), 64'd0);
        check("steal_count", 64'(seen_steal), 64'(exp_steal));
        check("overrun_count", 64'(seen_over), 64'(exp_over));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
